ed_sobel_window: RTL

//  Consumer/reader end of the edge-detection line buffering. Accepts a raster stream of 12-bit
//  RGB444 pixels, stores the two previous lines in circular line RAMs and assembles a 3x3 window.

---
 rtl/ed_pkg.sv | 19 +
 rtl/ed_line_ram.sv | 20 ++
 rtl/ed_sobel_window.sv | 116 +++++++++++
 3 files changed

// File: rtl/ed_pkg.sv
// Shared widths, default frame geometry and RGB444 field layout for the edge-detection path.
package ed_pkg;
  localparam int ED_PIX_W  = 12;
  localparam int ED_GREY_W = 6;
  localparam int ED_MAG_W  = 8;
  localparam int H_SIZE    = 320;
  localparam int V_SIZE    = 240;
  localparam int ED_CH_W   = 4;
  localparam int ED_R_LSB  = 8;
  localparam int ED_G_LSB  = 4;
  localparam int ED_B_LSB  = 0;

  // Luma approximation g = R + 2G + B, range 0..60.
  function automatic logic [ED_GREY_W-1:0] ed_grey(input logic [ED_PIX_W-1:0] pix);
    return ED_GREY_W'(pix[ED_R_LSB +: ED_CH_W])
         + ED_GREY_W'({pix[ED_G_LSB +: ED_CH_W], 1'b0})
         + ED_GREY_W'(pix[ED_B_LSB +: ED_CH_W]);
  endfunction
endpackage

// File: rtl/ed_line_ram.sv
// Single-clock line RAM: asynchronous read of the old word, write of the new word at the
// same address on the clock edge (read-before-write). Contents are never reset.
module ed_line_ram #(
  parameter int depth = 320,
  parameter int width = 6
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] addr,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata
);
  logic [width-1:0] mem [depth];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/ed_sobel_window.sv
// 3x3 Sobel edge magnitude over a raster RGB444 stream using two circular line RAMs.
// Build option: ED_THRESHOLD_EN turns the magnitude into a 0/255 binary result.
module ed_sobel_window
  import ed_pkg::*;
#(
  parameter int h_size = H_SIZE,
  parameter int v_size = V_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                sof,
  input  logic [ED_PIX_W-1:0] data_in,
  input  logic [7:0]          threshold,
  output logic                out_valid,
  output logic [ED_MAG_W-1:0] out
);
  localparam int CW = $clog2(h_size);
  localparam int RW = $clog2(v_size);

  // Handshake: enable qualifies data_in/sof as one accepted pixel (no backpressure);
  // out_valid is a one-cycle strobe, out holds its last value while out_valid is low.
  logic [CW-1:0]        col, cur_col;
  logic [RW-1:0]        row, cur_row;
  logic [ED_GREY_W-1:0] g, line1_q, line2_q;
  logic [ED_GREY_W-1:0] win [3][3];
  logic                 v1;

  assign cur_col = sof ? '0 : col;
  assign cur_row = sof ? '0 : row;
  assign g       = ed_grey(data_in);

  ed_line_ram #(.depth(h_size), .width(ED_GREY_W)) u_line1 (
    .clk(clk), .we(enable), .addr(cur_col), .wdata(g), .rdata(line1_q)
  );

  // line2 is fed from line1's old word, so it always lags one more row.
  ed_line_ram #(.depth(h_size), .width(ED_GREY_W)) u_line2 (
    .clk(clk), .we(enable), .addr(cur_col), .wdata(line1_q), .rdata(line2_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      if (cur_col == CW'(h_size - 1)) begin
        col <= '0;
        row <= (cur_row == RW'(v_size - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Stage 1: shift window left; row index 0 is the oldest line, 2 the newest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= enable && (cur_col >= CW'(2)) && (cur_row >= RW'(2));
      if (enable) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= line2_q;
        win[1][2] <= line1_q;
        win[2][2] <= g;
      end
    end
  end

  logic [7:0]          s_c0, s_c2, s_r0, s_r2;
  logic signed [8:0]   gx, gy;
  logic [8:0]          ax, ay;
  logic [9:0]          mag;
  logic [ED_MAG_W-1:0] result;

  always_comb begin
    s_c2   = 8'(win[0][2]) + {1'b0, win[1][2], 1'b0} + 8'(win[2][2]);
    s_c0   = 8'(win[0][0]) + {1'b0, win[1][0], 1'b0} + 8'(win[2][0]);
    s_r2   = 8'(win[2][0]) + {1'b0, win[2][1], 1'b0} + 8'(win[2][2]);
    s_r0   = 8'(win[0][0]) + {1'b0, win[0][1], 1'b0} + 8'(win[0][2]);
    gx     = $signed({1'b0, s_c2}) - $signed({1'b0, s_c0});
    gy     = $signed({1'b0, s_r2}) - $signed({1'b0, s_r0});
    ax     = gx[8] ? 9'(-gx) : 9'(gx);
    ay     = gy[8] ? 9'(-gy) : 9'(gy);
    mag    = {1'b0, ax} + {1'b0, ay};
`ifdef ED_THRESHOLD_EN
    result = (mag >= {2'b00, threshold}) ? 8'hFF : 8'h00;
`else
    result = (mag > 10'd255) ? 8'hFF : mag[7:0];
`endif
  end

`ifndef ED_THRESHOLD_EN
  logic unused_threshold;
  assign unused_threshold = ^threshold;
`endif

  // Stage 2 runs every clock; only v1 decides whether a new result is published.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) out <= result;
    end
  end
endmodule
